// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU and its iterative multiplier.
//   - function code numbers (legacy codes 0-4 keep their original meaning)
//   - FSM state encoding for alu_seq
//   - packed flag bundle carried alongside the registered result
// ---------------------------------------------------------------------------
package alu_pkg;

  // Function codes. Kept as plain integers so each user can size them to
  // its own FUNC_W without width warnings.
  localparam int unsigned FUNC_ADD = 0;
  localparam int unsigned FUNC_SUB = 1;
  localparam int unsigned FUNC_AND = 2;
  localparam int unsigned FUNC_OR  = 3;
  localparam int unsigned FUNC_NOR = 4;
  localparam int unsigned FUNC_SLT = 5;
  localparam int unsigned FUNC_SLL = 6;
  localparam int unsigned FUNC_SRL = 7;
  localparam int unsigned FUNC_MUL = 8;

  // Control states of alu_seq.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } alu_state_e;

  // Status flags that travel with every result.
  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
//
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   start          : one-cycle pulse; loads a/b and starts a new product
//   a, b           : multiplicand and multiplier (sampled only on start)
//   done           : high for one cycle once all WIDTH iterations are done;
//                    product is final during that cycle
//   product        : 2*WIDTH-bit accumulator contents
//
// Timing: start at edge E0, iterations on edges E1..E(WIDTH), done is high
// in the cycle after E(WIDTH) so the consumer registers the result at
// edge E(WIDTH+1).
// ---------------------------------------------------------------------------
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;

  // The accumulator starts as {0, multiplier}. Each step looks at the LSB,
  // conditionally adds the multiplicand into the upper half (keeping the
  // carry), then shifts the whole thing right by one. After WIDTH steps the
  // multiplier bits have all been consumed and acc holds the full product.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done      = 1'b0;
    addend    = acc_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    if (start) begin
      acc_d   = {{WIDTH{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end else begin
        acc_d = {upper_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Multiplier state; everything is cleared on reset so an abandoned
  // product can never leak into a later operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// have latency 1 and can stream at one per cycle; MUL runs on the iterative
// multiplier and returns WIDTH+1 cycles after it is accepted.
//
// Ports:
//   clk, rst              : clock and asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (accept = in_valid & in_ready)
//   a, b, func            : operands and function code (b low bits = shamt)
//   out_valid / out_ready : result handshake
//   out                   : registered result
//   zero_flag, neg_flag   : derived from the registered result
//   carry_flag            : ADD carry-out, SUB borrow, else 0
//   ovf_flag              : ADD/SUB signed overflow, MUL high-half nonzero
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int FUNC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic              zero_flag,
  output logic              neg_flag,
  output logic              carry_flag,
  output logic              ovf_flag
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(FUNC_ADD);
  localparam logic [FUNC_W-1:0] F_SUB = FUNC_W'(FUNC_SUB);
  localparam logic [FUNC_W-1:0] F_AND = FUNC_W'(FUNC_AND);
  localparam logic [FUNC_W-1:0] F_OR  = FUNC_W'(FUNC_OR);
  localparam logic [FUNC_W-1:0] F_NOR = FUNC_W'(FUNC_NOR);
  localparam logic [FUNC_W-1:0] F_SLT = FUNC_W'(FUNC_SLT);
  localparam logic [FUNC_W-1:0] F_SLL = FUNC_W'(FUNC_SLL);
  localparam logic [FUNC_W-1:0] F_SRL = FUNC_W'(FUNC_SRL);
  localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(FUNC_MUL);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  alu_flags_t         flags_q, flags_d;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  alu_flags_t         alu_flags;
  logic [WIDTH-1:0]   mul_lo;
  alu_flags_t         mul_flags;

  assign shamt  = b[SHAMT_W-1:0];
  assign is_mul = (func == F_MUL);
  assign accept = in_valid & in_ready;

  // Single-cycle datapath. ADD/SUB are done one bit wider so the top bit
  // is the carry (ADD) or the borrow (SUB, set when a < b unsigned).
  // Overflow: for ADD both operands share a sign and the result's sign
  // differs from a; for SUB the operand signs differ and the result's sign
  // differs from a. MUL and unused codes land in the default and give 0,
  // so unused codes report zero=1 with all other flags clear.
  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_flags = FLAGS_CLEAR;
    case (func)
      F_ADD: begin
        alu_res         = sum_ext[WIDTH-1:0];
        alu_flags.carry = sum_ext[WIDTH];
        alu_flags.ovf   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        alu_res         = diff_ext[WIDTH-1:0];
        alu_flags.carry = diff_ext[WIDTH];
        alu_flags.ovf   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      F_AND:   alu_res = a & b;
      F_OR:    alu_res = a | b;
      F_NOR:   alu_res = ~(a | b);
      F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F_SLL:   alu_res = a << shamt;
      F_SRL:   alu_res = a >> shamt;
      default: alu_res = '0;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[WIDTH-1];
  end

  // Flags for a finished multiply: low half is the result, any set bit in
  // the high half means the product did not fit.
  always_comb begin
    mul_lo          = mul_product[WIDTH-1:0];
    mul_flags       = FLAGS_CLEAR;
    mul_flags.zero  = (mul_lo == '0);
    mul_flags.neg   = mul_lo[WIDTH-1];
    mul_flags.ovf   = |mul_product[2*WIDTH-1:WIDTH];
  end

  // Input readiness. IDLE always takes work; MUL_BUSY never does; DONE
  // only takes work when the current result is being consumed in the same
  // cycle, which is what gives back-to-back throughput of one per cycle.
  // Held low for as long as reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:     in_ready = 1'b1;
      ST_MUL_BUSY: in_ready = 1'b0;
      ST_DONE:     in_ready = out_ready;
      default:     in_ready = 1'b0;
    endcase
    if (rst) begin
      in_ready = 1'b0;
    end
  end

  // Next-state logic. IDLE and DONE share the accept path: a single-cycle
  // op writes out/flags straight away and lands in DONE, a MUL kicks the
  // multiplier and waits in MUL_BUSY. DONE with the result consumed and
  // nothing new arriving drops back to IDLE. out/flags are left alone when
  // leaving DONE; they only matter while out_valid is high.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    flags_d   = flags_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = ST_MUL_BUSY;
          end else begin
            out_d   = alu_res;
            flags_d = alu_flags;
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          out_d   = mul_lo;
          flags_d = mul_flags;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      flags_q <= FLAGS_CLEAR;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );

  assign out_valid  = (state_q == ST_DONE);
  assign out        = out_q;
  assign zero_flag  = flags_q.zero;
  assign neg_flag   = flags_q.neg;
  assign carry_flag = flags_q.carry;
  assign ovf_flag   = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed self-checking bench for alu_seq (WIDTH=32, FUNC_W=4). Each test
// task drives its own vectors and compares against hand-computed values.
// Flags are compared as a 4-bit vector {zero, neg, carry, ovf}.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  func = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        zero_flag, neg_flag, carry_flag, ovf_flag;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  assign flags = {zero_flag, neg_flag, carry_flag, ovf_flag};

  alu_seq #(
    .WIDTH (32),
    .FUNC_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .carry_flag(carry_flag),
    .ovf_flag  (ovf_flag)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something upstream deadlocks.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one operation for a single edge and leave the bus idle.
  // Called at posedge+1 while the DUT is able to accept.
  task automatic issue(input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    func     = f;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Start a MUL and count edges until out_valid, noting any cycle in which
  // in_ready was seen high while waiting. Bounded at 40 edges.
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic ir_seen);
    issue(4'd8, x, y);
    lat     = 0;
    ir_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Consume whatever is pending and return to IDLE.
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL reset_out: got %h expected 00000000", out); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", in_ready); end
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_latency: got out_valid %b expected 1", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL add_wrap_out: got %h expected 00000000", out); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("[TB] FAIL add_wrap_flags: got %b expected 1010", flags); end
    issue(4'd0, 32'h7FFF_FFFF, 32'h1);
    checks++; if (out !== 32'h8000_0000) begin errors++; $display("[TB] FAIL add_ovf_out: got %h expected 80000000", out); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("[TB] FAIL add_ovf_flags: got %b expected 0101", flags); end
    drain();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_to_idle: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_logic_ops();
    out_ready = 1'b1;
    issue(4'd1, 32'h8000_0000, 32'h1);
    checks++; if (out !== 32'h7FFF_FFFF) begin errors++; $display("[TB] FAIL sub_ovf_out: got %h expected 7fffffff", out); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("[TB] FAIL sub_ovf_flags: got %b expected 0001", flags); end
    issue(4'd1, 32'h1, 32'h2);
    checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL sub_borrow_out: got %h expected ffffffff", out); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("[TB] FAIL sub_borrow_flags: got %b expected 0110", flags); end
    issue(4'd5, 32'hFFFF_FFFF, 32'h1);
    checks++; if (out !== 32'h1) begin errors++; $display("[TB] FAIL slt_true: got %h expected 00000001", out); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL slt_true_flags: got %b expected 0000", flags); end
    issue(4'd5, 32'h1, 32'hFFFF_FFFF);
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL slt_false: got %h expected 00000000", out); end
    issue(4'd4, 32'h0, 32'h0);
    checks++; if (out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL nor_out: got %h expected ffffffff", out); end
    checks++; if (flags !== 4'b0100) begin errors++; $display("[TB] FAIL nor_flags: got %b expected 0100", flags); end
    issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checks++; if (out !== 32'hF000_F000) begin errors++; $display("[TB] FAIL and_out: got %h expected f000f000", out); end
    issue(4'd3, 32'h0F0F_0000, 32'h0000_00F0);
    checks++; if (out !== 32'h0F0F_00F0) begin errors++; $display("[TB] FAIL or_out: got %h expected 0f0f00f0", out); end
    drain();
  endtask

  task automatic test_mul();
    int   lat;
    logic ir_seen;
    out_ready = 1'b1;
    run_mul(32'h0001_0000, 32'h0001_0000, lat, ir_seen);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mul_latency: got %0d edges expected 33", lat); end
    checks++; if (ir_seen !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_ready: got in_ready seen %b expected 0", ir_seen); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL mul_big_out: got %h expected 00000000", out); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("[TB] FAIL mul_big_flags: got %b expected 1001", flags); end
    run_mul(32'd7, 32'd6, lat, ir_seen);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mul_small_latency: got %0d edges expected 33", lat); end
    checks++; if (out !== 32'd42) begin errors++; $display("[TB] FAIL mul_small_out: got %0d expected 42", out); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL mul_small_flags: got %b expected 0000", flags); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [4];
    exp_res[0] = 32'd11; exp_res[1] = 32'd22; exp_res[2] = 32'd33; exp_res[3] = 32'd44;
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4);
    checks++; if (out !== 32'd7 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_first: got out %0d valid %b expected 7 valid 1", out, out_valid); end
    in_valid = 1'b1; func = 4'd0; a = 32'd10; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold_%0d: got out %0d valid %b in_ready %b expected 7 1 0", i, out, out_valid, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL done_ready_follow: got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; func = 4'd0; a = 32'((i + 1) * 10); b = 32'(i + 1);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out !== exp_res[i]) begin errors++; $display("[TB] FAIL b2b_%0d: got out %0d valid %b expected %0d valid 1", i, out, out_valid, exp_res[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_end: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    issue(4'd8, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL midrst_out: got %h expected 00000000", out); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 0000", flags); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 0", in_ready); end
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (40) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_no_result: got out_valid %b expected 0", out_valid); end
      @(posedge clk); #1;
    end
    issue(4'd0, 32'd1, 32'd1);
    checks++; if (out_valid !== 1'b1 || out !== 32'd2) begin errors++; $display("[TB] FAIL post_rst_add: got out %0d valid %b expected 2 valid 1", out, out_valid); end
    drain();
  endtask

  task automatic test_shift_illegal();
    out_ready = 1'b1;
    issue(4'd6, 32'h1, 32'h25);
    checks++; if (out !== 32'h20) begin errors++; $display("[TB] FAIL sll_out: got %h expected 00000020", out); end
    issue(4'd7, 32'h8000_0000, 32'h1F);
    checks++; if (out !== 32'h1) begin errors++; $display("[TB] FAIL srl_out: got %h expected 00000001", out); end
    issue(4'd7, 32'h0000_1234, 32'h20);
    checks++; if (out !== 32'h1234) begin errors++; $display("[TB] FAIL srl_zero_shamt: got %h expected 00001234", out); end
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    issue(4'd12, 32'd5, 32'd3);
    checks++; if (out !== 32'h0) begin errors++; $display("[TB] FAIL illegal_out: got %h expected 00000000", out); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("[TB] FAIL illegal_flags: got %b expected 1000", flags); end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_shift_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the single-cycle combinational datapath ALU. It adds a valid/ready handshake on input and output, and extends the op set with signed compare, logical shifts and an iterative multiply. It also produces a full flag set (zero, negative, carry, overflow). It sits between the register-read stage and the writeback/branch logic of the multi-cycle datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4, power of two)
FUNC_W, 4, width of function code
SHAMT_W (localparam), $clog2(WIDTH), shift amount bits taken from b[SHAMT_W-1:0]

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/func valid
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount in low SHAMT_W bits)
func  in  FUNC_W  operation select
out_valid  out  1  result/flags valid
out_ready  in  1  consumer takes result this cycle
out  out  WIDTH  registered result
zero_flag  out  1  out == 0
neg_flag  out  1  out[WIDTH-1]
carry_flag  out  1  ADD: carry-out; SUB: borrow (a < b unsigned); else 0
ovf_flag  out  1  ADD/SUB: signed overflow; MUL: any nonzero product bit above WIDTH-1; else 0

Behaviour:
- Reset (async, rst=1): state IDLE; out, all flags, out_valid = 0; multiplier registers cleared; in_ready = 0 while rst high.
- Function codes (legacy 0-4 unchanged): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT (signed, out = 1 or 0), 6 SLL, 7 SRL (logical), 8 MUL (low WIDTH bits of unsigned product). Codes 9..2^FUNC_W-1: out = 0, zero_flag = 1, other flags 0.
- Accept = in_valid & in_ready. a, b, func are sampled only on accept.
- States: IDLE, MUL_BUSY, DONE.
- IDLE: in_ready = 1. Single-cycle op accepted -> result and flags registered at that edge -> DONE (out_valid = 1 next cycle, latency 1). MUL accepted -> MUL_BUSY, counter = 0.
- MUL_BUSY: in_ready = 0. Radix-2 shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles. On the last iteration register out = acc[WIDTH-1:0] and ovf = |acc[2W-1:WIDTH] -> DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
- DONE: out_valid = 1; out and flags held stable while out_ready = 0. in_ready = out_ready.
  - out_ready & in_valid (single-cycle op): consume and accept in the same cycle, stay DONE with new result. Throughput is 1 op/cycle.
  - out_ready & in_valid (MUL): consume, go to MUL_BUSY, out_valid = 0.
  - out_ready & !in_valid: go to IDLE, out_valid = 0.
- out/flags are not cleared on leaving DONE. They are only meaningful while out_valid = 1.
- Arithmetic: ADD/SUB computed on WIDTH+1 bits for carry/borrow. Signed overflow = operand signs match (ADD) / differ (SUB) and result sign differs from a. Shifts by b[SHAMT_W-1:0] only; upper bits of b ignored. Shift amount 0 -> out = a.
- zero_flag and neg_flag are derived from the registered result value, never from a stale out.
- Reset mid-MUL: operation abandoned with no output; IDLE on release.
- in_valid while in_ready = 0: ignored. The producer must hold its inputs.

Decomposition:
- Shared package alu_pkg holds:
  - func code constants (FUNC_ADD..FUNC_MUL)
  - state typedef (IDLE/MUL_BUSY/DONE)
  - flag-bundle struct
- One sub-module, alu_mul_iter: shift-add multiplier with start, done, WIDTH-cycle counter and 2*WIDTH product output.
- alu_seq keeps the FSM, single-cycle datapath, flag generation and output registers.

Test Plan:
1. ADD a=0xFFFFFFFF b=0x1 -> out_valid next cycle; out=0, zero=1, carry=1, ovf=0, neg=0.
2. SUB a=0x80000000 b=0x1 -> out=0x7FFFFFFF, ovf=1, carry=0. Then SLT a=0xFFFFFFFF b=0x1 -> out=1. Then NOR a=0 b=0 -> out=0xFFFFFFFF, neg=1.
3. MUL a=0x00010000 b=0x00010000 -> in_ready=0 for 32 cycles; out_valid exactly 33 cycles after accept; out=0, zero=1, ovf=1. MUL 7*6 -> out=42, ovf=0.
4. ADD 3+4 with out_ready held low 5 cycles -> out=7 stable, in_ready=0 throughout. Then out_ready=1 with 4 back-to-back ADDs -> one result per cycle, no drops or duplicates.
5. Assert rst 10 cycles into a MUL -> out_valid=0 and all outputs 0 immediately (async). After release, ADD 1+1 -> out=2 at latency 1.
6. SLL a=0x1 b=0x25 (shamt 5) -> out=0x20. SRL a=0x80000000 b=0x1F -> out=0x1. Illegal func 12 -> out=0, zero=1, other flags 0.
